// File: rtl/timer_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_tick_pkg
// Description : Register map, control bits and FSM states shared by the
//               interval-timer tick master.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_tick_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTL_WORD_RUN  = 16'((1 << CTL_START) | (1 << CTL_CONT) | (1 << CTL_ITO));
    localparam logic [15:0] CTL_WORD_STOP = 16'(1 << CTL_STOP);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_PL   = 4'd1,
        ST_W_PH   = 4'd2,
        ST_W_CTL  = 4'd3,
        ST_RUN    = 4'd4,
        ST_W_STAT = 4'd5,
        ST_W_SNAP = 4'd6,
        ST_RD_L   = 4'd7,
        ST_RD_H   = 4'd8,
        ST_RD_D   = 4'd9,
        ST_W_STOP = 4'd10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_tick_master.sv
`default_nettype none
// ============================================================================
// Module      : timer_tick_master
// Description : Avalon-MM master that programs an interval timer, counts its
//               serviced timeouts and reads back 32-bit counter snapshots.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_tick_master
    import timer_tick_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snapshot,
    output logic              busy,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic              cfg_err,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              irq
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_period_hi;
    logic        r_pend_stop;
    logic        r_pend_snap;
    logic        w_start_ok;
    logic        w_cs;
    logic        w_wr_n;
    logic [2:0]  w_addr;
    logic [15:0] w_wdata;

    assign w_start_ok = cmd_start && (cfg_period != 32'd0);
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start_ok) w_next = ST_W_PL;
            ST_W_PL:   w_next = ST_W_PH;
            ST_W_PH:   w_next = ST_W_CTL;
            ST_W_CTL:  w_next = ST_RUN;
            ST_RUN: begin
                if (r_pend_stop || cmd_stop)          w_next = ST_W_STOP;
                else if (r_pend_snap || cmd_snapshot) w_next = ST_W_SNAP;
                else if (irq)                         w_next = ST_W_STAT;
            end
            ST_W_STAT: w_next = ST_RUN;
            ST_W_SNAP: w_next = ST_RD_L;
            ST_RD_L:   w_next = ST_RD_H;
            ST_RD_H:   w_next = ST_RD_D;
            ST_RD_D:   w_next = ST_RUN;
            ST_W_STOP: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus signals are decoded from the next state and registered, so each
    // access is on the bus during the cycle its state is current.
    always_comb begin
        w_cs    = 1'b0;
        w_wr_n  = 1'b1;
        w_addr  = 3'd0;
        w_wdata = 16'd0;
        case (w_next)
            ST_W_PL:   begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_PERIOD_L; w_wdata = cfg_period[15:0]; end
            ST_W_PH:   begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_PERIOD_H; w_wdata = r_period_hi; end
            ST_W_CTL:  begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_CONTROL;  w_wdata = CTL_WORD_RUN; end
            ST_W_STAT: begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_STATUS; end
            ST_W_SNAP: begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_SNAP_L; end
            ST_RD_L:   begin w_cs = 1'b1; w_addr = ADDR_SNAP_L; end
            ST_RD_H:   begin w_cs = 1'b1; w_addr = ADDR_SNAP_H; end
            ST_W_STOP: begin w_cs = 1'b1; w_wr_n = 1'b0; w_addr = ADDR_CONTROL;  w_wdata = CTL_WORD_STOP; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_address    <= 3'd0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= 16'd0;
            r_period_hi   <= 16'd0;
            r_pend_stop   <= 1'b0;
            r_pend_snap   <= 1'b0;
            tick_count    <= '0;
            snap_value    <= 32'd0;
            snap_valid    <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            av_address    <= w_addr;
            av_chipselect <= w_cs;
            av_write_n    <= w_wr_n;
            av_writedata  <= w_wdata;
            cfg_err       <= (r_state == ST_IDLE) && cmd_start && (cfg_period == 32'd0);
            snap_valid    <= (r_state == ST_RD_D);

            // Commands during a busy sequence are parked; clears below take precedence.
            if (r_state != ST_IDLE && r_state != ST_RUN) begin
                if (cmd_stop)     r_pend_stop <= 1'b1;
                if (cmd_snapshot) r_pend_snap <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_period_hi <= cfg_period[31:16];
                        tick_count  <= '0;
                        r_pend_stop <= 1'b0;
                        r_pend_snap <= 1'b0;
                    end
                end
                ST_W_STAT: tick_count <= tick_count + 1'b1;
                ST_RD_H:   snap_value[15:0] <= av_readdata;
                ST_RD_D: begin
                    snap_value[31:16] <= av_readdata;
                    r_pend_snap       <= 1'b0;
                end
                ST_W_STOP: begin
                    r_pend_stop <= 1'b0;
                    r_pend_snap <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_tick_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_tick_master
// Description : Directed bench pairing timer_tick_master with a behavioural
//               16-bit interval-timer slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_tick_master;

    localparam int TICK_W = 4;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       cfg_period;
    logic              cmd_start;
    logic              cmd_stop;
    logic              cmd_snapshot;
    logic              busy;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;
    logic              snap_valid;
    logic              cfg_err;
    logic [2:0]        av_address;
    logic              av_chipselect;
    logic              av_write_n;
    logic [15:0]       av_writedata;
    logic [15:0]       av_readdata;
    logic              irq;

    int n_pass  = 0;
    int n_total = 0;

    timer_tick_master #(.TICK_W(TICK_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_period   (cfg_period),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cmd_snapshot (cmd_snapshot),
        .busy         (busy),
        .tick_count   (tick_count),
        .snap_value   (snap_value),
        .snap_valid   (snap_valid),
        .cfg_err      (cfg_err),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Behavioural interval-timer slave: down-counter reloading from period.
    logic        s_to, s_run, s_ito, s_cont;
    logic [31:0] s_period, s_cnt, s_snap;
    logic [15:0] s_rdata;
    logic        s_tmo;

    assign s_tmo       = s_run && (s_cnt == 32'd0);
    assign irq         = s_to & s_ito;
    assign av_readdata = s_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_to <= 1'b0; s_run <= 1'b0; s_ito <= 1'b0; s_cont <= 1'b0;
            s_period <= 32'd0; s_cnt <= 32'd0; s_snap <= 32'd0; s_rdata <= 16'd0;
        end else begin
            s_rdata <= 16'd0;
            if (s_run) begin
                if (s_cnt == 32'd0) begin
                    s_cnt <= s_period;
                    s_to  <= 1'b1;
                    if (!s_cont) s_run <= 1'b0;
                end else begin
                    s_cnt <= s_cnt - 32'd1;
                end
            end
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: if (!s_tmo) s_to <= 1'b0;
                    3'd1: begin
                        s_ito  <= av_writedata[0];
                        s_cont <= av_writedata[1];
                        if (av_writedata[3])      s_run <= 1'b0;
                        else if (av_writedata[2]) s_run <= 1'b1;
                    end
                    3'd2: begin
                        s_period[15:0] <= av_writedata;
                        s_cnt <= {s_period[31:16], av_writedata};
                        s_run <= 1'b0;
                    end
                    3'd3: begin
                        s_period[31:16] <= av_writedata;
                        s_cnt <= {av_writedata, s_period[15:0]};
                        s_run <= 1'b0;
                    end
                    3'd4, 3'd5: s_snap <= s_cnt;
                    default: ;
                endcase
            end else if (av_chipselect) begin
                case (av_address)
                    3'd0:    s_rdata <= {14'd0, s_run, s_to};
                    3'd4:    s_rdata <= s_snap[15:0];
                    3'd5:    s_rdata <= s_snap[31:16];
                    default: s_rdata <= 16'd0;
                endcase
            end
        end
    end

    // Bus monitor sampled on the falling edge.
    acc_t log_q[$];
    int   irq_rise_q[$];
    int   cyc = 0;
    int   stat_cnt = 0;
    int   snapv_cnt = 0;
    logic irq_d = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (av_chipselect) begin
            log_q.push_back('{cyc, !av_write_n, av_address, av_writedata});
            if (!av_write_n && av_address == 3'd0) stat_cnt++;
        end
        if (snap_valid) snapv_cnt++;
        if (irq && !irq_d) irq_rise_q.push_back(cyc);
        irq_d = irq;
    end

    function automatic acc_t ent(int i);
        acc_t e;
        e = '{-1, 1'b0, 3'd7, 16'hDEAD};
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    task automatic clear_log();
        log_q.delete();
        irq_rise_q.delete();
        stat_cnt  = 0;
        snapv_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snapshot = 1'b0;
        cfg_period = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic start_timer(input logic [31:0] period);
        @(negedge clk);
        cfg_period = period; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (tick_count !== 4'd0) $display("FAIL reset_tick: got %0d want 0", tick_count); else n_pass++;
        n_total++; if (snap_value !== 32'd0 || snap_valid !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL reset_snap_err: got %h/%b/%b want 0/0/0", snap_value, snap_valid, cfg_err); else n_pass++;
        n_total++; if (av_chipselect !== 1'b0 || av_write_n !== 1'b1 || av_address !== 3'd0 || av_writedata !== 16'd0)
            $display("FAIL reset_bus: got cs%b wn%b a%0d d%h want cs0 wn1 a0 d0000",
                     av_chipselect, av_write_n, av_address, av_writedata); else n_pass++;
    endtask

    task automatic test_start_ticks();
        acc_t e0, e1, e2;
        int   n_pl;
        do_reset();
        start_timer(32'h0000_0009);
        repeat (10) @(negedge clk);
        cmd_start = 1'b1; cfg_period = 32'h0000_0003;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (stat_cnt >= 5) break;
            @(negedge clk);
        end
        @(negedge clk);
        e0 = ent(0); e1 = ent(1); e2 = ent(2);
        n_total++; if (e0.wr !== 1'b1 || e0.addr !== 3'd2 || e0.data !== 16'h0009)
            $display("FAIL cfg_pl: got wr%b a%0d d%h want wr1 a2 d0009", e0.wr, e0.addr, e0.data); else n_pass++;
        n_total++; if (e1.wr !== 1'b1 || e1.addr !== 3'd3 || e1.data !== 16'h0000 || e1.cyc != e0.cyc + 1)
            $display("FAIL cfg_ph: got wr%b a%0d d%h cyc%0d want wr1 a3 d0000 cyc%0d", e1.wr, e1.addr, e1.data, e1.cyc, e0.cyc + 1); else n_pass++;
        n_total++; if (e2.wr !== 1'b1 || e2.addr !== 3'd1 || e2.data !== 16'h0007 || e2.cyc != e0.cyc + 2)
            $display("FAIL cfg_ctl: got wr%b a%0d d%h cyc%0d want wr1 a1 d0007 cyc%0d", e2.wr, e2.addr, e2.data, e2.cyc, e0.cyc + 2); else n_pass++;
        n_total++; if (tick_count !== 4'd5) $display("FAIL tick_5: got %0d want 5", tick_count); else n_pass++;
        n_total++; if (irq_rise_q.size() != 5) $display("FAIL irq_count: got %0d want 5", irq_rise_q.size()); else n_pass++;
        foreach (irq_rise_q[k]) begin
            int found = 0;
            foreach (log_q[j])
                if (log_q[j].wr && log_q[j].addr == 3'd0 && log_q[j].data == 16'd0 &&
                    log_q[j].cyc > irq_rise_q[k] && log_q[j].cyc <= irq_rise_q[k] + 2) found = 1;
            n_total++; if (found != 1) $display("FAIL irq_service: irq at cyc %0d got no status clear want one within 2", irq_rise_q[k]); else n_pass++;
        end
        n_pl = 0;
        foreach (log_q[j]) if (log_q[j].wr && log_q[j].addr == 3'd2) n_pl++;
        n_total++; if (n_pl != 1) $display("FAIL start_while_busy: got %0d period writes want 1", n_pl); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_run: got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_cfg_err();
        do_reset();
        @(negedge clk);
        cfg_period = 32'd0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        n_total++; if (cfg_err !== 1'b1 || busy !== 1'b0) $display("FAIL cfg_err_pulse: got err%b busy%b want err1 busy0", cfg_err, busy); else n_pass++;
        @(negedge clk);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_width: got %b want 0", cfg_err); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (log_q.size() != 0 || busy !== 1'b0) $display("FAIL cfg_err_nobus: got %0d accesses busy%b want 0 busy0", log_q.size(), busy); else n_pass++;
    endtask

    task automatic test_snapshot();
        acc_t e0, e1, e2;
        do_reset();
        start_timer(32'h0001_86A0);
        repeat (50) @(negedge clk);
        clear_log();
        cmd_snapshot = 1'b1;
        @(negedge clk);
        cmd_snapshot = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (snap_valid) break;
            @(negedge clk);
        end
        n_total++; if (snap_valid !== 1'b1) $display("FAIL snap_valid: got %b want 1", snap_valid); else n_pass++;
        n_total++; if (snap_value !== s_snap || snap_value > 32'h0001_86A0)
            $display("FAIL snap_value: got %h want %h (<= 000186a0)", snap_value, s_snap); else n_pass++;
        e0 = ent(0); e1 = ent(1); e2 = ent(2);
        n_total++; if (e0.wr !== 1'b1 || e0.addr !== 3'd4 || e1.wr !== 1'b0 || e1.addr !== 3'd4 ||
                       e2.wr !== 1'b0 || e2.addr !== 3'd5 || e1.cyc != e0.cyc + 1 || e2.cyc != e0.cyc + 2)
            $display("FAIL snap_bus: got %b/%0d %b/%0d %b/%0d want 1/4 0/4 0/5",
                     e0.wr, e0.addr, e1.wr, e1.addr, e2.wr, e2.addr); else n_pass++;
        @(negedge clk);
        n_total++; if (snap_valid !== 1'b0) $display("FAIL snap_valid_width: got %b want 0", snap_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        acc_t e2, e3;
        do_reset();
        @(negedge clk);
        cfg_period = 32'h0000_0009; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        @(negedge clk);
        n_total++; if (av_address !== 3'd3 || av_chipselect !== 1'b1) $display("FAIL in_wph: got a%0d cs%b want a3 cs1", av_address, av_chipselect); else n_pass++;
        cmd_snapshot = 1'b1; cmd_stop = 1'b1;
        @(negedge clk);
        cmd_snapshot = 1'b0; cmd_stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        e2 = ent(2); e3 = ent(3);
        n_total++; if (e2.addr !== 3'd1 || e2.data !== 16'h0007 || e3.wr !== 1'b1 || e3.addr !== 3'd1 || e3.data !== 16'h0008)
            $display("FAIL pend_stop_seq: got a%0d d%h, a%0d d%h want a1 d0007, a1 d0008", e2.addr, e2.data, e3.addr, e3.data); else n_pass++;
        n_total++; if (log_q.size() != 4 || snapv_cnt != 0) $display("FAIL pend_no_snap: got %0d accesses %0d snaps want 4 0", log_q.size(), snapv_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0 || s_run !== 1'b0) $display("FAIL pend_stopped: got busy%b run%b want 0 0", busy, s_run); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        start_timer(32'h0000_0002);
        for (int i = 0; i < 300; i++) begin
            if (stat_cnt >= 17) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_total++; if (tick_count !== 4'd1) $display("FAIL tick_wrap: got %0d want 1", tick_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        acc_t e0, e1, e2;
        int   hit;
        do_reset();
        start_timer(32'h0001_86A0);
        repeat (20) @(negedge clk);
        cmd_snapshot = 1'b1;
        @(negedge clk);
        cmd_snapshot = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            if (av_chipselect && av_write_n && av_address == 3'd4) begin hit = 1; break; end
            @(negedge clk);
        end
        n_total++; if (hit != 1) $display("FAIL reach_rd_l: got %0d want 1", hit); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || av_chipselect !== 1'b0 || av_write_n !== 1'b1 || av_address !== 3'd0 || av_writedata !== 16'd0)
            $display("FAIL async_reset_bus: got busy%b cs%b wn%b a%0d d%h want 0 0 1 0 0000",
                     busy, av_chipselect, av_write_n, av_address, av_writedata); else n_pass++;
        n_total++; if (tick_count !== 4'd0 || snap_value !== 32'd0 || snap_valid !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL async_reset_out: got t%0d s%h v%b e%b want 0", tick_count, snap_value, snap_valid, cfg_err); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        start_timer(32'h0000_0009);
        repeat (3) @(negedge clk);
        e0 = ent(0); e1 = ent(1); e2 = ent(2);
        n_total++; if (e0.addr !== 3'd2 || e0.data !== 16'h0009 || e1.addr !== 3'd3 || e2.addr !== 3'd1 || e2.data !== 16'h0007)
            $display("FAIL restart_cfg: got a%0d/%h a%0d a%0d/%h want a2/0009 a3 a1/0007",
                     e0.addr, e0.data, e1.addr, e2.addr, e2.data); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snapshot = 1'b0; cfg_period = 32'd0;
        test_reset();
        test_start_ticks();
        test_cfg_err();
        test_snapshot();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
